// File: rtl/tl_data_slave.sv
// tl_data_slave: TileLink-UL style word-addressed data memory slave.
// It accepts one A-channel request at a time and answers each with one
// D-channel beat after WAIT_CYCLES extra cycles.
//
// Build option TL_SLAVE_MISALIGN_ERR_EN:
//   defined   - a request with a_address[1:0] != 0, or with any address bit
//               above the index field set, gets d_error=1, writes nothing
//               and returns d_data=0.
//   undefined - the low and high address bits are ignored, and the word
//               index wraps modulo DEPTH_WORDS.
//
// state | meaning
// IDLE  | a_ready=1, waiting for an A-channel request
// WAIT  | request accepted, wait counter running down
// RESP  | d_valid=1, response held until d_ready
module tl_data_slave #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_opcode,
  input  logic [3:0]  a_source,
  input  logic [31:0] a_address,
  input  logic [3:0]  a_mask,
  input  logic [31:0] a_data,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [42:0] d_channel
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

`ifdef TL_SLAVE_MISALIGN_ERR_EN
  localparam bit MISALIGN_ERR_EN = 1'b1;
`else
  localparam bit MISALIGN_ERR_EN = 1'b0;
`endif

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  localparam logic [2:0] D_ACK      = 3'd0;
  localparam logic [2:0] D_ACK_DATA = 3'd1;
  localparam logic [2:0] D_SIZE     = 3'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   load_resp;
  logic   accept;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [3:0]       cnt_q;
  logic [2:0]       op_q;
  logic [3:0]       src_q;
  logic [IDX_W-1:0] idx_q;
  logic             err_q;
  logic [42:0]      d_channel_q;

  logic [IDX_W-1:0] a_idx;
  logic             addr_bad;
  logic             addr_err;
  logic             a_is_put;
  logic             wr_en;
  logic [3:0]       wr_be;

  logic [2:0]       cur_op;
  logic [3:0]       cur_src;
  logic [IDX_W-1:0] cur_idx;
  logic             cur_addr_err;
  logic             resp_is_get;
  logic             resp_err;
  logic [31:0]      rd_word;
  logic [42:0]      resp_word;

  // Request decode: word index, address legality and write strobes
  always_comb begin
    a_idx    = a_address[IDX_W+1:2];
    addr_bad = (a_address[1:0] != 2'b00) || ((a_address >> (IDX_W + 2)) != 32'd0);
    addr_err = MISALIGN_ERR_EN && addr_bad;
    a_is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
    accept   = a_valid && a_ready;
    wr_en    = accept && a_is_put && !addr_err;
    wr_be    = (a_opcode == OP_PUT_FULL) ? 4'hF : a_mask;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; reset forces both handshakes low
  always_comb begin
    state_d   = state_q;
    a_ready   = 1'b0;
    d_valid   = 1'b0;
    load_resp = 1'b0;
    case (state_q)
      IDLE: begin
        a_ready = 1'b1;
        if (a_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_d   = RESP;
            load_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          load_resp = 1'b1;
        end
      end
      RESP: begin
        d_valid = 1'b1;
        if (d_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (reset) begin
      a_ready   = 1'b0;
      d_valid   = 1'b0;
      load_resp = 1'b0;
      state_d   = IDLE;
    end
  end

  // Response source: live request when leaving IDLE directly, else latched
  always_comb begin
    if (state_q == IDLE) begin
      cur_op       = a_opcode;
      cur_src      = a_source;
      cur_idx      = a_idx;
      cur_addr_err = addr_err;
    end else begin
      cur_op       = op_q;
      cur_src      = src_q;
      cur_idx      = idx_q;
      cur_addr_err = err_q;
    end
    rd_word     = mem[cur_idx];
    resp_is_get = (cur_op == OP_GET);
    resp_err    = cur_addr_err ||
                  !((cur_op == OP_GET) || (cur_op == OP_PUT_FULL) || (cur_op == OP_PUT_PART));
    resp_word   = {(resp_is_get ? D_ACK_DATA : D_ACK), D_SIZE, cur_src, resp_err,
                   ((resp_is_get && !resp_err) ? rd_word : 32'd0)};
  end

  // Request latch, wait counter and response register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 4'd0;
      op_q        <= 3'd0;
      src_q       <= 4'd0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      d_channel_q <= 43'd0;
    end else begin
      if (accept) begin
        op_q  <= a_opcode;
        src_q <= a_source;
        idx_q <= a_idx;
        err_q <= addr_err;
        cnt_q <= 4'(WAIT_CYCLES);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (load_resp) begin
        d_channel_q <= resp_word;
      end
    end
  end

  // Byte-enabled memory write on the acceptance edge; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en && wr_be[i]) begin
        mem[a_idx][8*i +: 8] <= a_data[8*i +: 8];
      end
    end
  end

  assign d_channel = d_channel_q;

endmodule

// File: tb/tb_tl_data_slave.sv
// Directed bench for tl_data_slave: vector table plus hand sequences for
// response stall, address handling and reset during WAIT.
module tb_tl_data_slave;

  localparam int W = 2;
  localparam int D = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [42:0] d_channel;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tl_data_slave #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_opcode  (a_opcode),
    .a_source  (a_source),
    .a_address (a_address),
    .a_mask    (a_mask),
    .a_data    (a_data),
    .d_valid   (d_valid),
    .d_ready   (d_ready),
    .d_channel (d_channel)
  );

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  src;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [42:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [42:0] rsp(input logic [2:0] op, input logic [3:0] src,
                                      input logic err, input logic [31:0] data);
    return {op, 3'd2, src, err, data};
  endfunction

  task automatic chk(input string name, input logic [42:0] act, input logic [42:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One full transaction; checks latency, stall stability and a_ready recovery
  task automatic xact(input string name, input logic [2:0] op, input logic [3:0] src,
                      input logic [31:0] addr, input logic [3:0] mask,
                      input logic [31:0] data, input int stall,
                      output logic [42:0] resp);
    int n;
    int lat;
    logic [42:0] held;
    @(negedge clk);
    a_valid   = 1'b1;
    a_opcode  = op;
    a_source  = src;
    a_address = addr;
    a_mask    = mask;
    a_data    = data;
    n = 0;
    while (!a_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " a_ready before accept"}, 43'(a_ready), 43'd1);
    @(posedge clk);
    #1;
    a_valid  = 1'b0;
    a_data   = 32'h0;
    a_mask   = 4'h0;
    lat = 0;
    @(negedge clk);
    while (!d_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk_int({name, " latency"}, lat, W);
    held = d_channel;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk({name, " stall d_channel"}, d_channel, held);
      chk({name, " stall a_ready"}, 43'(a_ready), 43'd0);
      chk({name, " stall d_valid"}, 43'(d_valid), 43'd1);
    end
    d_ready = 1'b1;
    @(posedge clk);
    #1;
    d_ready = 1'b0;
    @(negedge clk);
    chk({name, " a_ready after D"}, 43'(a_ready), 43'd1);
    chk({name, " d_valid after D"}, 43'(d_valid), 43'd0);
    resp = held;
  endtask

  initial begin
    logic [42:0] r;

    vecs[0]  = '{3'd0, 4'h3, 32'h10,  4'hF, 32'hDEADBEEF, rsp(3'd0, 4'h3, 1'b0, 32'h0)};
    vecs[1]  = '{3'd4, 4'h5, 32'h10,  4'h0, 32'h0,        rsp(3'd1, 4'h5, 1'b0, 32'hDEADBEEF)};
    vecs[2]  = '{3'd0, 4'h1, 32'h20,  4'hF, 32'h11223344, rsp(3'd0, 4'h1, 1'b0, 32'h0)};
    vecs[3]  = '{3'd1, 4'h2, 32'h20,  4'h5, 32'hAABBCCDD, rsp(3'd0, 4'h2, 1'b0, 32'h0)};
    vecs[4]  = '{3'd4, 4'h7, 32'h20,  4'hF, 32'h0,        rsp(3'd1, 4'h7, 1'b0, 32'h11BB33DD)};
    vecs[5]  = '{3'd0, 4'h4, 32'h30,  4'hF, 32'h12345678, rsp(3'd0, 4'h4, 1'b0, 32'h0)};
    vecs[6]  = '{3'd2, 4'h9, 32'h30,  4'hF, 32'h55,       rsp(3'd0, 4'h9, 1'b1, 32'h0)};
    vecs[7]  = '{3'd7, 4'h8, 32'h30,  4'hF, 32'hFFFFFFFF, rsp(3'd0, 4'h8, 1'b1, 32'h0)};
    vecs[8]  = '{3'd1, 4'hB, 32'h30,  4'h0, 32'hFFFFFFFF, rsp(3'd0, 4'hB, 1'b0, 32'h0)};
    vecs[9]  = '{3'd4, 4'hA, 32'h30,  4'h0, 32'h0,        rsp(3'd1, 4'hA, 1'b0, 32'h12345678)};
    vecs[10] = '{3'd0, 4'hC, 32'hFFC, 4'hF, 32'hCAFEF00D, rsp(3'd0, 4'hC, 1'b0, 32'h0)};
    vecs[11] = '{3'd4, 4'hF, 32'hFFC, 4'h0, 32'h0,        rsp(3'd1, 4'hF, 1'b0, 32'hCAFEF00D)};

    reset     = 1'b1;
    a_valid   = 1'b0;
    d_ready   = 1'b0;
    a_opcode  = 3'd0;
    a_source  = 4'd0;
    a_address = 32'd0;
    a_mask    = 4'd0;
    a_data    = 32'd0;

    @(negedge clk);
    chk("reset a_ready", 43'(a_ready), 43'd0);
    @(negedge clk);
    chk("reset a_ready held", 43'(a_ready), 43'd0);
    chk("reset d_valid", 43'(d_valid), 43'd0);
    chk("reset d_channel", d_channel, 43'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-reset a_ready", 43'(a_ready), 43'd1);
    chk("post-reset d_valid", 43'(d_valid), 43'd0);

    for (int v = 0; v < 12; v++) begin
      xact($sformatf("vec%0d", v), vecs[v].op, vecs[v].src, vecs[v].addr,
           vecs[v].mask, vecs[v].data, 0, r);
      chk($sformatf("vec%0d resp", v), r, vecs[v].exp);
    end

    xact("stall get", 3'd4, 4'h6, 32'h10, 4'h0, 32'h0, 5, r);
    chk("stall get resp", r, rsp(3'd1, 4'h6, 1'b0, 32'hDEADBEEF));

    xact("init word0", 3'd0, 4'h1, 32'h0, 4'hF, 32'hA5A5A5A5, 0, r);
    chk("init word0 resp", r, rsp(3'd0, 4'h1, 1'b0, 32'h0));
    xact("get 0x13", 3'd4, 4'h2, 32'h13, 4'h0, 32'h0, 0, r);
`ifdef TL_SLAVE_MISALIGN_ERR_EN
    chk("get 0x13 resp", r, rsp(3'd1, 4'h2, 1'b1, 32'h0));
`else
    chk("get 0x13 resp", r, rsp(3'd1, 4'h2, 1'b0, 32'hDEADBEEF));
`endif
    xact("put high", 3'd0, 4'h3, 32'(D * 4), 4'hF, 32'h0BADC0DE, 0, r);
`ifdef TL_SLAVE_MISALIGN_ERR_EN
    chk("put high resp", r, rsp(3'd0, 4'h3, 1'b1, 32'h0));
`else
    chk("put high resp", r, rsp(3'd0, 4'h3, 1'b0, 32'h0));
`endif
    xact("get word0", 3'd4, 4'h4, 32'h0, 4'h0, 32'h0, 0, r);
`ifdef TL_SLAVE_MISALIGN_ERR_EN
    chk("get word0 resp", r, rsp(3'd1, 4'h4, 1'b0, 32'hA5A5A5A5));
`else
    chk("get word0 resp", r, rsp(3'd1, 4'h4, 1'b0, 32'h0BADC0DE));
`endif

    // Put to 0x40 accepted, then reset lands one edge later while in WAIT
    @(negedge clk);
    chk("rst-wait a_ready", 43'(a_ready), 43'd1);
    a_valid   = 1'b1;
    a_opcode  = 3'd0;
    a_source  = 4'h5;
    a_address = 32'h40;
    a_mask    = 4'hF;
    a_data    = 32'h7;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    reset   = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rst-wait d_valid c%0d", i), 43'(d_valid), 43'd0);
      chk($sformatf("rst-wait a_ready c%0d", i), 43'(a_ready), 43'd1);
    end
    xact("get 0x40", 3'd4, 4'h9, 32'h40, 4'h0, 32'h0, 0, r);
    chk("get 0x40 resp", r, rsp(3'd1, 4'h9, 1'b0, 32'h7));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
